// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register file and its writeback arbiter.
// Both blocks import these so that address and data widths stay identical.
package regfile_wb_arbiter_pkg;

    localparam int RF_AW    = 3;
    localparam int RF_DW    = 32;
    localparam int RF_DEPTH = 8;
    localparam int CNT_W    = 16;

    // Width of an index into an n-wide requester vector (never narrower than one bit)
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter: one-hot grant to the first valid
// requester after last_grant, searching upward with wrap-around.
// Kept generic so the memory-port arbiter can reuse it.
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int LW = idx_width(N)
) (
    input  logic          enable,
    input  logic [N-1:0]  valid,
    input  logic [LW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [LW-1:0] grant_idx,
    output logic          grant_any
);

    logic [N-1:0]  grant_s;
    logic [LW-1:0] idx_s;
    logic          found_s;
    logic [LW-1:0] cand_s;

    // Walk the candidates last_grant+1 .. last_grant+N (mod N); first valid wins
    always_comb begin
        grant_s = '0;
        idx_s   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 1; k <= N; k++) begin
            cand_s = LW'((int'(last_grant) + k) % N);
            if (enable && !found_s && valid[cand_s]) begin
                grant_s[cand_s] = 1'b1;
                idx_s           = cand_s;
                found_s         = 1'b1;
            end else begin
                // this candidate loses or an earlier one already won
            end
        end
    end

    assign grant     = grant_s;
    assign grant_idx = idx_s;
    assign grant_any = found_s;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single write port of the 8x32 register file.
// Round-robin between N_REQ requesters; the winner is registered onto
// wea/waddr/wdata so the register file writes one edge after the accept.
// busy flags every register with a write pending or in the output stage.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic                wea,
    output logic [AW-1:0]       waddr,
    output logic [DW-1:0]       wdata,
    output logic [2**AW-1:0]    busy,
    output logic [CNT_W-1:0]    grant_cnt
);

    localparam int LW    = idx_width(N_REQ);
    localparam int DEPTH = 2**AW;

    logic [LW-1:0]    last_grant_r;
    logic [CNT_W-1:0] grant_cnt_r;
    logic             wea_r;
    logic [AW-1:0]    waddr_r;
    logic [DW-1:0]    wdata_r;

    logic             arb_en_s;
    logic [N_REQ-1:0] grant_s;
    logic [LW-1:0]    grant_idx_s;
    logic             grant_any_s;
    logic [AW-1:0]    sel_addr_s;
    logic [DW-1:0]    sel_data_s;
    logic [DEPTH-1:0] busy_s;

    // No grant may be issued while in reset or while decode stalls us
    assign arb_en_s = ~reset & ~stall;

    rr_arbiter #(
        .N  (N_REQ),
        .LW (LW)
    ) u_rr (
        .enable     (arb_en_s),
        .valid      (req_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s),
        .grant_any  (grant_any_s)
    );

    // One-hot mux of the winning requester's address and data
    always_comb begin
        sel_addr_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_s[i]) begin
                sel_addr_s = req_addr[i*AW +: AW];
                sel_data_s = req_data[i*DW +: DW];
            end else begin
                // not the winner, contributes nothing
            end
        end
    end

    // Output stage, priority pointer and accept counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wea_r        <= 1'b0;
            waddr_r      <= '0;
            wdata_r      <= '0;
            grant_cnt_r  <= '0;
            last_grant_r <= LW'(N_REQ - 1);
        end else if (grant_any_s) begin
            wea_r        <= 1'b1;
            waddr_r      <= sel_addr_s;
            wdata_r      <= sel_data_s;
            grant_cnt_r  <= grant_cnt_r + 16'd1;
            last_grant_r <= grant_idx_s;
        end else begin
            wea_r        <= 1'b0;
        end
    end

    // Hazard vector: output-stage write plus every pending request, per register
    always_comb begin
        busy_s = '0;
        for (int r = 0; r < DEPTH; r++) begin
            if (wea_r && (waddr_r == AW'(r))) begin
                busy_s[r] = 1'b1;
            end else begin
                busy_s[r] = 1'b0;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && (req_addr[i*AW +: AW] == AW'(r))) begin
                    busy_s[r] = 1'b1;
                end else begin
                    // this requester does not target register r
                end
            end
        end
    end

    assign req_ready = grant_s;
    assign wea       = wea_r;
    assign waddr     = waddr_r;
    assign wdata     = wdata_r;
    assign busy      = busy_s;
    assign grant_cnt = grant_cnt_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a cycle-level reference model
// and a simple register file fed from the DUT write port.
module tb_regfile_wb_arbiter;

    localparam int N     = 2;
    localparam int AW    = 3;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic [N-1:0]     req_valid;
    logic [N*AW-1:0]  req_addr;
    logic [N*DW-1:0]  req_data;
    logic [N-1:0]     req_ready;
    logic             wea;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic [DEPTH-1:0] busy;
    logic [15:0]      grant_cnt;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wea       (wea),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .grant_cnt (grant_cnt)
    );

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int               m_last = N - 1;
    logic             m_wea = 1'b0;
    logic [AW-1:0]    m_waddr = '0;
    logic [DW-1:0]    m_wdata = '0;
    int unsigned      m_cnt = 0;
    logic [DW-1:0]    m_rf [DEPTH];
    logic [DW-1:0]    rf   [DEPTH];
    logic [N-1:0]     p_valid = '0;
    logic [N-1:0]     p_acc = '0;
    logic [N*AW-1:0]  p_addr = '0;
    logic [N*DW-1:0]  p_data = '0;

    // Requester that must be accepted now, or -1
    function automatic int winner();
        if (reset || stall) return -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [DEPTH-1:0] model_busy();
        logic [DEPTH-1:0] b;
        b = '0;
        for (int r = 0; r < DEPTH; r++) begin
            if (m_wea && int'(m_waddr) == r) b[r] = 1'b1;
            for (int i = 0; i < N; i++)
                if (req_valid[i] && int'(req_addr[i*AW +: AW]) == r) b[r] = 1'b1;
        end
        return b;
    endfunction

    // Model state advance at each rising edge
    always @(posedge clk) begin
        int w;
        if (m_wea) m_rf[m_waddr] = m_wdata;
        w = winner();
        p_valid = req_valid;
        p_addr  = req_addr;
        p_data  = req_data;
        p_acc   = '0;
        if (reset) begin
            m_wea = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = 0; m_last = N - 1;
        end else if (w >= 0) begin
            p_acc[w] = 1'b1;
            m_wea   = 1'b1;
            m_waddr = req_addr[w*AW +: AW];
            m_wdata = req_data[w*DW +: DW];
            m_last  = w;
            m_cnt   = (m_cnt + 1) % 65536;
        end else begin
            m_wea = 1'b0;
        end
    end

    // Register file as the DUT write port drives it
    always @(posedge clk) begin
        if (wea === 1'b1) rf[waddr] <= wdata;
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            int w;
            w = winner();
            check("req_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
            check("busy", 32'(busy), 32'(model_busy()));
            check("wea", 32'(wea), 32'(m_wea));
            check("waddr", 32'(waddr), 32'(m_waddr));
            check("wdata", wdata, m_wdata);
            check("grant_cnt", 32'(grant_cnt), m_cnt);
            for (int i = 0; i < N; i++) begin
                if (p_valid[i] && !p_acc[i] && req_valid[i]) begin
                    check("hold_addr", 32'(req_addr[i*AW +: AW]), 32'(p_addr[i*AW +: AW]));
                    check("hold_data", req_data[i*DW +: DW], p_data[i*DW +: DW]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] seq [6];

    initial begin
        for (int r = 0; r < DEPTH; r++) begin
            m_rf[r] = '0;
            rf[r]   = '0;
        end
        reset     = 1'b1;
        stall     = 1'b0;
        req_valid = 2'b11;
        req_addr  = {3'd1, 3'd2};
        req_data  = {32'hBBBBCCCC, 32'hCCCCDDDD};

        // reset held 3 cycles with both requesters valid
        step();
        started = 1'b1;
        step();
        step();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_wea", 32'(wea), 32'd0);
        check("rst_cnt", 32'(grant_cnt), 32'd0);
        reset = 1'b0;
        #1;
        check("first_grant", 32'(req_ready), 32'h1);

        // single requester 0: addr 2
        req_valid = 2'b01;
        step();
        check("single_wea", 32'(wea), 32'd1);
        check("single_waddr", 32'(waddr), 32'd2);
        check("single_wdata", wdata, 32'hCCCCDDDD);
        check("single_cnt", 32'(grant_cnt), 32'd1);
        req_valid = 2'b00;
        step();
        check("single_rf2", rf[2], 32'hCCCCDDDD);

        // contention: last_grant=0 so requester 1 goes first, then alternation
        req_valid = 2'b11;
        req_addr  = {3'd1, 3'd0};
        req_data  = {32'hBBBBCCCC, 32'hAAAABBBB};
        for (int k = 0; k < 6; k++) begin
            #1;
            seq[k] = req_ready;
            step();
        end
        req_valid = 2'b00;
        for (int k = 0; k < 6; k++)
            check("contention_seq", 32'(seq[k]), (k % 2 == 0) ? 32'h2 : 32'h1);
        check("contention_cnt", 32'(grant_cnt), 32'd7);
        step();
        check("contention_rf0", rf[0], 32'hAAAABBBB);
        check("contention_rf1", rf[1], 32'hBBBBCCCC);

        // same-address collision on r3 with last_grant=0
        req_valid = 2'b11;
        req_addr  = {3'd3, 3'd3};
        req_data  = {32'hEEEEFFFF, 32'hDDDDAAAA};
        #1;
        check("coll_ready1", 32'(req_ready), 32'h2);
        check("coll_busy3a", 32'(busy[3]), 32'd1);
        step();
        req_valid = 2'b01;
        #1;
        check("coll_ready0", 32'(req_ready), 32'h1);
        check("coll_wdata1", wdata, 32'hEEEEFFFF);
        step();
        req_valid = 2'b00;
        #1;
        check("coll_wdata0", wdata, 32'hDDDDAAAA);
        check("coll_busy3b", 32'(busy[3]), 32'd1);
        step();
        check("coll_busy3c", 32'(busy[3]), 32'd0);
        check("coll_rf3", rf[3], 32'hDDDDAAAA);
        check("coll_cnt", 32'(grant_cnt), 32'd9);

        // stall for 4 cycles with both valid
        stall     = 1'b1;
        req_valid = 2'b11;
        req_addr  = {3'd6, 3'd5};
        req_data  = {32'h33334444, 32'h11112222};
        for (int k = 0; k < 4; k++) begin
            #1;
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_busy", 32'(busy & 8'h60), 32'h60);
            step();
        end
        check("stall_wea", 32'(wea), 32'd0);
        check("stall_cnt", 32'(grant_cnt), 32'd9);
        stall = 1'b0;
        #1;
        check("resume_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        check("resume_cnt", 32'(grant_cnt), 32'd11);
        check("resume_rf5", rf[5], 32'h11112222);
        check("resume_rf6", rf[6], 32'h33334444);

        // counter wrap: continuous grants up to and past 0xFFFF
        req_valid = 2'b11;
        req_addr  = {3'd1, 3'd0};
        req_data  = {32'hBBBBCCCC, 32'hAAAABBBB};
        repeat (65534 - 11) step();
        check("wrap_fffe", 32'(grant_cnt), 32'h0000FFFE);
        step();
        check("wrap_ffff", 32'(grant_cnt), 32'h0000FFFF);
        step();
        check("wrap_0000", 32'(grant_cnt), 32'h00000000);
        step();
        check("wrap_0001", 32'(grant_cnt), 32'h00000001);

        // reset in the cycle after an accept
        reset     = 1'b1;
        req_valid = 2'b00;
        step();
        check("midrst_wea", 32'(wea), 32'd0);
        check("midrst_cnt", 32'(grant_cnt), 32'd0);
        req_valid = 2'b01;
        req_addr  = {3'd1, 3'd7};
        req_data  = {32'hBBBBCCCC, 32'hDEADBEEF};
        #1;
        check("midrst_ready", 32'(req_ready), 32'd0);
        step();
        check("midrst_wea2", 32'(wea), 32'd0);
        check("midrst_rf7", rf[7], 32'd0);
        reset = 1'b0;
        #1;
        check("postrst_ready", 32'(req_ready), 32'h1);
        step();
        check("postrst_waddr", 32'(waddr), 32'd7);
        check("postrst_cnt", 32'(grant_cnt), 32'd1);
        req_valid = 2'b00;
        step();
        check("postrst_rf7", rf[7], 32'hDEADBEEF);

        for (int r = 0; r < DEPTH; r++)
            check("final_rf", rf[r], m_rf[r]);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
